interrupt_priority_arbiter: RTL and testbench

//  Collects NUM_SRC external interrupt lines, latches rising edges as pending,

---
 rtl/interrupt_priority_arbiter_if.sv | 34 +++
 rtl/interrupt_priority_arbiter.sv | 128 ++++++++++++
 tb/tb_interrupt_priority_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_priority_arbiter_if.sv
// Interrupt arbiter bus: raw interrupt lines, mask write port, ISR handshake
// pulses from the core, and the request/vector/status signals back to it.
//   irq_src, mask_wr_en, mask_wr_data, isr_enter, isr_return : core -> arbiter
//   irq_req, irq_id, isr_vector, irq_mask, irq_pending,
//   in_service                                               : arbiter -> core
interface interrupt_priority_arbiter_if #(
    parameter int unsigned NUM_SRC = 8
) ();
    localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] irq_src;
    logic               mask_wr_en;
    logic [NUM_SRC-1:0] mask_wr_data;
    logic               isr_enter;
    logic               isr_return;
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic [31:0]        isr_vector;
    logic [NUM_SRC-1:0] irq_mask;
    logic [NUM_SRC-1:0] irq_pending;
    logic               in_service;

    // Arbiter side
    modport slave (
        input  irq_src, mask_wr_en, mask_wr_data, isr_enter, isr_return,
        output irq_req, irq_id, isr_vector, irq_mask, irq_pending, in_service
    );

    // Core / interrupt-source side
    modport master (
        output irq_src, mask_wr_en, mask_wr_data, isr_enter, isr_return,
        input  irq_req, irq_id, isr_vector, irq_mask, irq_pending, in_service
    );
endinterface

// File: rtl/interrupt_priority_arbiter.sv
// Fixed-priority interrupt arbiter (source 0 highest). Latches rising edges of
// the interrupt lines as pending, masks them, raises a single request to the
// core with the winner's id and ISR vector, and tracks the enter/return
// handshake so that only one interrupt is in service at a time.
//   clk, reset : clock and synchronous active-high reset
//   bus        : interrupt_priority_arbiter_if.slave (see interface header)
module interrupt_priority_arbiter #(
    parameter int unsigned NUM_SRC       = 8,
    parameter int unsigned ISR_BASE      = 500,
    parameter int unsigned VECTOR_STRIDE = 16,
    parameter int unsigned RESET_MASK    = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    interrupt_priority_arbiter_if.slave         bus
);
    localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               irq_req_q, irq_req_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [31:0]        vec_q, vec_d;
    logic               svc_q, svc_d;

    logic [NUM_SRC-1:0] edge_c;
    logic [NUM_SRC-1:0] cand_c;
    logic [NUM_SRC-1:0] pending_clr_c;
    logic [ID_W-1:0]    winner_c;
    logic [31:0]        winner_vec_c;

    // Lowest-index enabled pending source wins; vector wraps mod 2^32
    always_comb begin
        cand_c   = pending_q & mask_q;
        winner_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                winner_c = ID_W'(i);
            end
        end
        winner_vec_c = 32'(ISR_BASE) + 32'(winner_c) * 32'(VECTOR_STRIDE);
    end

    // Next-state, pending and output logic
    always_comb begin
        state_d       = state_q;
        irq_req_d     = irq_req_q;
        irq_id_d      = irq_id_q;
        vec_d         = vec_q;
        svc_d         = svc_q;
        pending_clr_c = '0;
        edge_c        = bus.irq_src & ~src_q;
        mask_d        = bus.mask_wr_en ? bus.mask_wr_data : mask_q;

        case (state_q)
            ST_IDLE: begin
                if (|cand_c) begin
                    irq_id_d  = winner_c;
                    vec_d     = winner_vec_c;
                    irq_req_d = 1'b1;
                    state_d   = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // isr_return is deliberately ignored here, even alongside enter
                if (bus.isr_enter) begin
                    pending_clr_c[irq_id_q] = 1'b1;
                    irq_req_d               = 1'b0;
                    svc_d                   = 1'b1;
                    state_d                 = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (bus.isr_return) begin
                    svc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                irq_req_d = 1'b0;
                svc_d     = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // A new edge on the source being cleared keeps it pending
        pending_d = (pending_q & ~pending_clr_c) | edge_c;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= NUM_SRC'(RESET_MASK);
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
            vec_q     <= 32'(ISR_BASE);
            svc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= bus.irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            vec_q     <= vec_d;
            svc_q     <= svc_d;
        end
    end

    assign bus.irq_req     = irq_req_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.isr_vector  = vec_q;
    assign bus.irq_mask    = mask_q;
    assign bus.irq_pending = pending_q;
    assign bus.in_service  = svc_q;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Directed, table-driven bench for interrupt_priority_arbiter (NUM_SRC=8,
// ISR_BASE=500, VECTOR_STRIDE=16, RESET_MASK=0). Each vector holds the inputs
// for one cycle and the outputs expected right after the following posedge.
module tb_interrupt_priority_arbiter;

    logic clk;
    logic reset;

    interrupt_priority_arbiter_if #(.NUM_SRC(8)) bus ();

    interrupt_priority_arbiter #(
        .NUM_SRC      (8),
        .ISR_BASE     (500),
        .VECTOR_STRIDE(16),
        .RESET_MASK   (0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  src;
        logic        mwe;
        logic [7:0]  mwd;
        logic        ent;
        logic        ret;
        logic        req;
        logic [2:0]  id;
        logic [31:0] vec;
        logic [7:0]  pend;
        logic [7:0]  mask;
        logic        svc;
    } vec_t;

    int checks;
    int errors;
    int step_no;

    function automatic vec_t v(input logic rst, input logic [7:0] src,
                               input logic mwe, input logic [7:0] mwd,
                               input logic ent, input logic ret,
                               input logic req, input logic [2:0] id,
                               input logic [31:0] vec, input logic [7:0] pend,
                               input logic [7:0] mask, input logic svc);
        vec_t r;
        r.rst = rst; r.src = src; r.mwe = mwe; r.mwd = mwd;
        r.ent = ent; r.ret = ret; r.req = req; r.id = id;
        r.vec = vec; r.pend = pend; r.mask = mask; r.svc = svc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h",
                     name, step_no, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare all outputs after the posedge
    task automatic step(input vec_t t);
        @(negedge clk);
        reset            = t.rst;
        bus.irq_src      = t.src;
        bus.mask_wr_en   = t.mwe;
        bus.mask_wr_data = t.mwd;
        bus.isr_enter    = t.ent;
        bus.isr_return   = t.ret;
        @(posedge clk);
        #1;
        chk("irq_req",     32'(bus.irq_req),     32'(t.req));
        chk("irq_id",      32'(bus.irq_id),      32'(t.id));
        chk("isr_vector",  bus.isr_vector,       t.vec);
        chk("irq_pending", 32'(bus.irq_pending), 32'(t.pend));
        chk("irq_mask",    32'(bus.irq_mask),    32'(t.mask));
        chk("in_service",  32'(bus.in_service),  32'(t.svc));
        step_no++;
    endtask

    vec_t tbl[$];

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        reset            = 1'b1;
        bus.irq_src      = '0;
        bus.mask_wr_en   = 1'b0;
        bus.mask_wr_data = '0;
        bus.isr_enter    = 1'b0;
        bus.isr_return   = 1'b0;

        //              rst src   mwe mwd   ent ret  req id vec  pend  mask  svc
        // Reset state, then single edge on src3
        tbl.push_back(v(1, 8'h00, 0, 8'h00, 0, 0,  0, 0, 500, 8'h00, 8'h00, 0));
        tbl.push_back(v(0, 8'h00, 1, 8'hFF, 0, 0,  0, 0, 500, 8'h00, 8'hFF, 0));
        tbl.push_back(v(0, 8'h08, 0, 8'h00, 0, 0,  0, 0, 500, 8'h08, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 3, 548, 8'h08, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 3, 548, 8'h08, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 1, 0,  0, 3, 548, 8'h00, 8'hFF, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  0, 3, 548, 8'h00, 8'hFF, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 1,  0, 3, 548, 8'h00, 8'hFF, 0));
        // Simultaneous edges on src5 and src2: 2 first, then 5
        tbl.push_back(v(0, 8'h24, 0, 8'h00, 0, 0,  0, 3, 548, 8'h24, 8'hFF, 0));
        tbl.push_back(v(0, 8'h24, 0, 8'h00, 0, 0,  1, 2, 532, 8'h24, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 1, 0,  0, 2, 532, 8'h20, 8'hFF, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 1,  0, 2, 532, 8'h20, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 5, 580, 8'h20, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 1, 0,  0, 5, 580, 8'h00, 8'hFF, 1));
        // enter+return together in SERVICE: only return acts
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 1, 1,  0, 5, 580, 8'h00, 8'hFF, 0));
        // Masked edge held pending until the mask is opened
        tbl.push_back(v(0, 8'h00, 1, 8'hF7, 0, 0,  0, 5, 580, 8'h00, 8'hF7, 0));
        tbl.push_back(v(0, 8'h08, 0, 8'h00, 0, 0,  0, 5, 580, 8'h08, 8'hF7, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  0, 5, 580, 8'h08, 8'hF7, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  0, 5, 580, 8'h08, 8'hF7, 0));
        tbl.push_back(v(0, 8'h00, 1, 8'hFF, 0, 0,  0, 5, 580, 8'h08, 8'hFF, 0));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 3, 548, 8'h08, 8'hFF, 0));
        // Masking the granted source does not withdraw the request
        tbl.push_back(v(0, 8'h00, 1, 8'hF7, 0, 0,  1, 3, 548, 8'h08, 8'hF7, 0));
        // enter+return together in REQUEST: only enter acts
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 1, 1,  0, 3, 548, 8'h00, 8'hF7, 1));
        tbl.push_back(v(0, 8'h00, 0, 8'h00, 0, 1,  0, 3, 548, 8'h00, 8'hF7, 0));
        tbl.push_back(v(0, 8'h00, 1, 8'hFF, 0, 0,  0, 3, 548, 8'h00, 8'hFF, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Level held high for 20 cycles: exactly one grant; spurious return in IDLE
        step(v(0, 8'h02, 0, 8'h00, 0, 0,  0, 3, 548, 8'h02, 8'hFF, 0));
        step(v(0, 8'h02, 0, 8'h00, 0, 0,  1, 1, 516, 8'h02, 8'hFF, 0));
        step(v(0, 8'h02, 0, 8'h00, 1, 0,  0, 1, 516, 8'h00, 8'hFF, 1));
        step(v(0, 8'h02, 0, 8'h00, 0, 1,  0, 1, 516, 8'h00, 8'hFF, 0));
        for (int k = 0; k < 15; k++)
            step(v(0, 8'h02, 0, 8'h00, 0, 0,  0, 1, 516, 8'h00, 8'hFF, 0));
        step(v(0, 8'h02, 0, 8'h00, 0, 1,  0, 1, 516, 8'h00, 8'hFF, 0));
        step(v(0, 8'h00, 0, 8'h00, 0, 0,  0, 1, 516, 8'h00, 8'hFF, 0));

        // New src1 edge in the same cycle as isr_enter for id 1
        step(v(0, 8'h02, 0, 8'h00, 0, 0,  0, 1, 516, 8'h02, 8'hFF, 0));
        step(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 1, 516, 8'h02, 8'hFF, 0));
        step(v(0, 8'h02, 0, 8'h00, 1, 0,  0, 1, 516, 8'h02, 8'hFF, 1));
        step(v(0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 516, 8'h02, 8'hFF, 0));
        step(v(0, 8'h00, 0, 8'h00, 0, 0,  1, 1, 516, 8'h02, 8'hFF, 0));
        step(v(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 516, 8'h00, 8'hFF, 1));
        step(v(0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 516, 8'h00, 8'hFF, 0));

        // Reset while in SERVICE with pending=0x30
        step(v(0, 8'h31, 0, 8'h00, 0, 0,  0, 1, 516, 8'h31, 8'hFF, 0));
        step(v(0, 8'h31, 0, 8'h00, 0, 0,  1, 0, 500, 8'h31, 8'hFF, 0));
        step(v(0, 8'h31, 0, 8'h00, 1, 0,  0, 0, 500, 8'h30, 8'hFF, 1));
        step(v(0, 8'h31, 0, 8'h00, 0, 0,  0, 0, 500, 8'h30, 8'hFF, 1));
        step(v(1, 8'h00, 0, 8'h00, 0, 0,  0, 0, 500, 8'h00, 8'h00, 0));
        step(v(0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 500, 8'h00, 8'h00, 0));
        // Reset mask is all-disabled: an edge pends but is not requested
        step(v(0, 8'h01, 0, 8'h00, 0, 0,  0, 0, 500, 8'h01, 8'h00, 0));
        step(v(0, 8'h01, 0, 8'h00, 0, 0,  0, 0, 500, 8'h01, 8'h00, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
